// File: rtl/datapath_seq.sv
// datapath_seq: W-bit register file, 1-bit shifter, ALU and A/B/C/status
// registers, driven by an internal read-A / read-B / execute / writeback
// sequencer behind a single start/ready handshake.
// Optional feature: define DATAPATH_CARRY_EN to build the carry flag
// (status_out[3]); without it the carry bit is tied to 0.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int PCW   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      ready,
    output logic                      done,
    input  logic [$clog2(NREG)-1:0]   rn,
    input  logic [$clog2(NREG)-1:0]   rm,
    input  logic [$clog2(NREG)-1:0]   rd,
    input  logic [1:0]                shift,
    input  logic [1:0]                asel,
    input  logic [1:0]                bsel,
    input  logic [1:0]                aluop,
    input  logic [1:0]                vsel,
    input  logic                      wb_en,
    input  logic                      set_status,
    input  logic [WIDTH-1:0]          mdata,
    input  logic [WIDTH-1:0]          sximm8,
    input  logic [WIDTH-1:0]          sximm5,
    input  logic [PCW-1:0]            pc,
    output logic [3:0]                status_out,
    output logic [WIDTH-1:0]          datapath_out,
    output logic [NREG*WIDTH-1:0]     reg_out
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXEC,
        S_WB
    } state_t;

    state_t state, state_nx;
    logic   accept;

    // Operation fields captured at the accept edge
    logic [RW-1:0]    op_rn, op_rm, op_rd;
    logic [1:0]       op_shift, op_asel, op_bsel, op_aluop, op_vsel;
    logic             op_wb_en, op_set_status;
    logic [WIDTH-1:0] op_mdata, op_sximm8, op_sximm5;
    logic [PCW-1:0]   op_pc;

    logic [WIDTH-1:0] rf [NREG];
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    logic [3:0]       status_reg;

    logic [WIDTH-1:0] pc_ext, b_shifted, a_in, b_in, b_op, add_res, alu_res, wb_val;
    logic             is_arith, is_sub, carry_out;
    logic [3:0]       flags;

    // Sequencer next state and handshake decode
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nx = S_RDA;
            end
            S_RDA:  state_nx = S_RDB;
            S_RDB:  state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            S_WB: begin
                ready    = 1'b1;
                done     = 1'b1;
                state_nx = start ? S_RDA : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept = start & ready;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Capture every control and operand field when an operation is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rn <= '0; op_rm <= '0; op_rd <= '0;
            op_shift <= '0; op_asel <= '0; op_bsel <= '0;
            op_aluop <= '0; op_vsel <= '0;
            op_wb_en <= 1'b0; op_set_status <= 1'b0;
            op_mdata <= '0; op_sximm8 <= '0; op_sximm5 <= '0; op_pc <= '0;
        end else if (accept) begin
            op_rn <= rn; op_rm <= rm; op_rd <= rd;
            op_shift <= shift; op_asel <= asel; op_bsel <= bsel;
            op_aluop <= aluop; op_vsel <= vsel;
            op_wb_en <= wb_en; op_set_status <= set_status;
            op_mdata <= mdata; op_sximm8 <= sximm8; op_sximm5 <= sximm5; op_pc <= pc;
        end
    end

    // Operand selection, shifter and ALU operand conditioning
    always_comb begin
        pc_ext = '0;
        pc_ext[PCW-1:0] = op_pc;
        case (op_shift)
            2'b01:   b_shifted = {b_reg[WIDTH-2:0], 1'b0};
            2'b10:   b_shifted = {1'b0, b_reg[WIDTH-1:1]};
            2'b11:   b_shifted = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
            default: b_shifted = b_reg;
        endcase
        case (op_asel)
            2'b00:   a_in = a_reg;
            2'b10:   a_in = pc_ext;
            default: a_in = '0;
        endcase
        case (op_bsel)
            2'b00:   b_in = b_shifted;
            2'b01:   b_in = op_sximm5;
            2'b10:   b_in = op_sximm8;
            default: b_in = '0;
        endcase
        is_sub   = (op_aluop == 2'b01);
        is_arith = (op_aluop[1] == 1'b0);
        b_op     = is_sub ? ~b_in : b_in;
    end

    // Shared adder: subtraction is A + ~B + 1, so carry-out is NOT borrow
`ifdef DATAPATH_CARRY_EN
    logic [WIDTH:0] add_ext;
    assign add_ext   = {1'b0, a_in} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    assign add_res   = add_ext[WIDTH-1:0];
    assign carry_out = add_ext[WIDTH];
`else
    assign add_res   = a_in + b_op + {{(WIDTH-1){1'b0}}, is_sub};
    assign carry_out = 1'b0;
`endif

    // ALU result, flags and writeback source selection
    always_comb begin
        case (op_aluop)
            2'b10:   alu_res = a_in & b_in;
            2'b11:   alu_res = ~b_in;
            default: alu_res = add_res;
        endcase
        flags[3] = is_arith & carry_out;
        flags[2] = (alu_res == '0);
        flags[1] = is_arith & (a_in[WIDTH-1] == b_op[WIDTH-1]) & (add_res[WIDTH-1] != a_in[WIDTH-1]);
        flags[0] = alu_res[WIDTH-1];
        case (op_vsel)
            2'b00:   wb_val = c_reg;
            2'b01:   wb_val = op_mdata;
            2'b10:   wb_val = op_sximm8;
            default: wb_val = pc_ext;
        endcase
    end

    // A/B/C/status registers, loaded in their sequencer steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            status_reg <= '0;
        end else begin
            if (state == S_RDA) a_reg <= rf[op_rn];
            if (state == S_RDB) b_reg <= rf[op_rm];
            if (state == S_EXEC) begin
                c_reg <= alu_res;
                if (op_set_status) status_reg <= flags;
            end
        end
    end

    // Register file; the writeback commits on the WB edge so a following op reads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (state == S_WB && op_wb_en) begin
            rf[op_rd] <= wb_val;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_reg_out
        assign reg_out[i*WIDTH +: WIDTH] = rf[i];
    end

    assign datapath_out = c_reg;
    assign status_out   = status_reg;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: self-checking bench for datapath_seq with an
// operation-level reference model and directed literal checks.
module tb_datapath_seq;
    localparam int W    = 16;
    localparam int NREG = 8;
    localparam int PCW  = 8;
    localparam int RW   = $clog2(NREG);
    localparam longint SMAX = (longint'(1) << (W-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W-1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              ready, done;
    logic [RW-1:0]     rn = '0, rm = '0, rd = '0;
    logic [1:0]        shift = '0, asel = '0, bsel = '0, aluop = '0, vsel = '0;
    logic              wb_en = 1'b0, set_status = 1'b0;
    logic [W-1:0]      mdata = 16'hA5A5, sximm8 = '0, sximm5 = 16'hFFFD;
    logic [PCW-1:0]    pc = 8'h3C;
    logic [3:0]        status_out;
    logic [W-1:0]      datapath_out;
    logic [NREG*W-1:0] reg_out;

    int n_checks = 0;
    int n_fail   = 0;

    datapath_seq #(.WIDTH(W), .NREG(NREG), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .done(done),
        .rn(rn), .rm(rm), .rd(rd), .shift(shift), .asel(asel), .bsel(bsel),
        .aluop(aluop), .vsel(vsel), .wb_en(wb_en), .set_status(set_status),
        .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .pc(pc),
        .status_out(status_out), .datapath_out(datapath_out), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    // Reference model: operation-level view of the datapath
    logic [W-1:0]      m_regs [NREG] = '{default: '0};
    logic [W-1:0]      m_c = '0;
    logic [3:0]        m_status = '0;
    int                m_phase = 0;
    logic [W-1:0]      p_res = '0, p_val = '0;
    logic [3:0]        p_flags = '0;
    logic              p_wb = 1'b0, p_set = 1'b0;
    logic [RW-1:0]     p_rd = '0;
    logic              m_acc;
    logic [NREG*W-1:0] exp_flat;

    task automatic checkOutput(input string name, input logic [NREG*W-1:0] act,
                               input logic [NREG*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept();
        logic [W-1:0] a, b, bsh, pcx, res;
        longint ua, ub, sa, sb, sr;
        logic cf, vf;
        pcx = '0;
        pcx[PCW-1:0] = pc;
        case (asel)
            2'b00:   a = m_regs[rn];
            2'b10:   a = pcx;
            default: a = '0;
        endcase
        bsh = m_regs[rm];
        case (shift)
            2'b01:   bsh = bsh << 1;
            2'b10:   bsh = bsh >> 1;
            2'b11:   bsh = $unsigned($signed(bsh) >>> 1);
            default: ;
        endcase
        case (bsel)
            2'b00:   b = bsh;
            2'b01:   b = sximm5;
            2'b10:   b = sximm8;
            default: b = '0;
        endcase
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cf = 1'b0;
        vf = 1'b0;
        case (aluop)
            2'b00: begin
                res = W'(ua + ub);
                cf  = (ua + ub) >= (longint'(1) << W);
                sr  = sa + sb;
                vf  = (sr > SMAX) || (sr < SMIN);
            end
            2'b01: begin
                res = W'(ua - ub);
                cf  = (ua >= ub);
                sr  = sa - sb;
                vf  = (sr > SMAX) || (sr < SMIN);
            end
            2'b10:   res = a & b;
            default: res = ~b;
        endcase
`ifndef DATAPATH_CARRY_EN
        cf = 1'b0;
`endif
        p_res   = res;
        p_flags = {cf, (res == '0), vf, res[W-1]};
        case (vsel)
            2'b00:   p_val = res;
            2'b01:   p_val = mdata;
            2'b10:   p_val = sximm8;
            default: p_val = pcx;
        endcase
        p_wb  = wb_en;
        p_set = set_status;
        p_rd  = rd;
    endtask

    // Model update at each clock edge, aborted by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_c = '0;
            m_status = '0;
            m_phase = 0;
        end else begin
            m_acc = start && (m_phase == 0 || m_phase == 4);
            if (m_phase == 4 && p_wb) m_regs[p_rd] = p_val;
            if (m_phase == 3) begin
                m_c = p_res;
                if (p_set) m_status = p_flags;
            end
            if (m_acc) begin
                model_accept();
                m_phase = 1;
            end else if (m_phase == 4) m_phase = 0;
            else if (m_phase != 0)     m_phase = m_phase + 1;
        end
    end

    // Compare every DUT output with the model on each falling edge
    always @(negedge clk) begin
        for (int i = 0; i < NREG; i++) exp_flat[i*W +: W] = m_regs[i];
        checkOutput("ready", ready, (m_phase == 0 || m_phase == 4));
        checkOutput("done", done, (m_phase == 4));
        checkOutput("datapath_out", datapath_out, m_c);
        checkOutput("status_out", status_out, m_status);
        checkOutput("reg_out", reg_out, exp_flat);
    end

    task automatic applyStimulus(input logic [RW-1:0] rn_i, input logic [RW-1:0] rm_i,
                                 input logic [RW-1:0] rd_i, input logic [1:0] shift_i,
                                 input logic [1:0] asel_i, input logic [1:0] bsel_i,
                                 input logic [1:0] aluop_i, input logic [1:0] vsel_i,
                                 input logic wb_i, input logic set_i, input logic [W-1:0] imm8_i);
        @(negedge clk); #1;
        rn = rn_i; rm = rm_i; rd = rd_i; shift = shift_i; asel = asel_i; bsel = bsel_i;
        aluop = aluop_i; vsel = vsel_i; wb_en = wb_i; set_status = set_i; sximm8 = imm8_i;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [RW-1:0] rn_i, input logic [RW-1:0] rm_i,
                          input logic [RW-1:0] rd_i, input logic [1:0] shift_i,
                          input logic [1:0] asel_i, input logic [1:0] bsel_i,
                          input logic [1:0] aluop_i, input logic [1:0] vsel_i,
                          input logic wb_i, input logic set_i, input logic [W-1:0] imm8_i);
        int lat;
        applyStimulus(rn_i, rm_i, rd_i, shift_i, asel_i, bsel_i, aluop_i, vsel_i, wb_i, set_i, imm8_i);
        wait_done(lat);
        checkOutput("done_latency", lat, 4);
    endtask

    task automatic load_imm(input logic [RW-1:0] rd_i, input logic [W-1:0] val);
        run_op(0, 0, rd_i, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, val);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones;
        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_dp", datapath_out, 16'h0000);
        checkOutput("reset_status", status_out, 4'h0);
        checkOutput("reset_regs", reg_out, '0);
        #1 rst_n = 1'b1;

        // Load immediate with latency check; write visible one edge after done
        run_op(0, 0, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 16'h0042);
        checkOutput("li_r3_before_wb", reg_out[3*W +: W], 16'h0000);
        @(negedge clk);
        checkOutput("li_r3", reg_out[3*W +: W], 16'h0042);
        checkOutput("li_done_low", done, 1'b0);

        // Add with shift: 5 + (3 << 1) = 11
        load_imm(1, 16'd5);
        load_imm(2, 16'd3);
        run_op(1, 2, 4, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 16'h0000);
        checkOutput("addsh_c", datapath_out, 16'd11);
        checkOutput("addsh_status", status_out, 4'b0000);
        @(negedge clk);
        checkOutput("addsh_r4", reg_out[4*W +: W], 16'd11);

        // Signed overflow: 0x7FFF + 1
        load_imm(1, 16'h7FFF);
        load_imm(2, 16'h0001);
        run_op(1, 2, 6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 16'h0000);
        checkOutput("ovf_c", datapath_out, 16'h8000);
        checkOutput("ovf_status", status_out, 4'b0011);
        @(negedge clk);

        // Zero result from subtraction: 7 - 7
        load_imm(1, 16'd7);
        load_imm(2, 16'd7);
        run_op(1, 2, 6, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 16'h0000);
        checkOutput("sub_c", datapath_out, 16'h0000);
`ifdef DATAPATH_CARRY_EN
        checkOutput("sub_status", status_out, 4'b1100);
`else
        checkOutput("sub_status", status_out, 4'b0100);
`endif
        @(negedge clk);

        // Further operations covered by the model: and, not with asr, pc operand, no-write
        run_op(3, 4, 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 16'h0000);
        @(negedge clk);
        load_imm(2, 16'h8004);
        run_op(0, 2, 3, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 16'h0000);
        @(negedge clk);
        checkOutput("not_asr_r3", reg_out[3*W +: W], 16'h3FFD);
        run_op(0, 0, 1, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 1'b1, 1'b1, 16'h0000);
        @(negedge clk);
        run_op(0, 2, 5, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 16'h0000);
        @(negedge clk);

        // Back-to-back hazard with ignored start pulses while busy
        dones = 0;
        @(negedge clk); #1;
        rn = 0; rm = 0; rd = 5; shift = 0; asel = 0; bsel = 0; aluop = 0;
        vsel = 2'b10; wb_en = 1; set_status = 0; sximm8 = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        rd = 0; sximm8 = 16'hDEAD;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        #1;
        rn = 5; rm = 0; rd = 7; shift = 0; asel = 2'b00; bsel = 2'b11; aluop = 2'b00;
        vsel = 2'b00; wb_en = 1; set_status = 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 5; n <= 14; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("b2b_dones", dones, 2);
        checkOutput("b2b_r5", reg_out[5*W +: W], 16'd9);
        checkOutput("b2b_r7", reg_out[7*W +: W], 16'd9);

        // Reset asserted during EXEC aborts the operation
        applyStimulus(0, 0, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 16'h1234);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_ready", ready, 1'b1);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        checkOutput("abort_regs", reg_out, '0);
        checkOutput("abort_dp", datapath_out, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
